data_memory_hs: RTL and testbench

Parametrised data memory with a valid/ready request/response handshake, per-byte write enables and a configurable number of wait states. It replaces the fixed single-cycle data memory model. It sits behind the core's load/store unit, or behind a bus adapter, so the pipeline can be exercised against non-zero memory latency and back-pressure. It accepts one transaction at a time and returns exactly one response per accepted request.

---
 rtl/data_memory_hs_pkg.sv | 27 ++
 rtl/data_memory_hs_array.sv | 53 +++++
 rtl/data_memory_hs.sv | 163 ++++++++++++++++
 tb/tb_data_memory_hs.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_hs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_hs_pkg
// Brief    : Shared types, constants and helpers for data_memory_hs.
// Revision : 1.0 - initial release
// ============================================================================
package data_memory_hs_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int LATENCY_CNT_WIDTH = 4;

    function automatic int byte_lanes(input int data_width);
        return data_width / 8;
    endfunction

    // Storage index width; a single-word array still needs a 1-bit index.
    function automatic int index_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_memory_hs_array.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_hs_array
// Brief    : DEPTH x DATA_WIDTH storage with byte-lane write merge and a
//            registered read port. Storage itself is not reset.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_hs_array
    import data_memory_hs_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1024
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             wr_en,
    input  logic [index_width(DEPTH)-1:0]    wr_idx,
    input  logic [DATA_WIDTH/8-1:0]          wr_byteena,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic                             rd_en,
    input  logic                             rd_zero,
    input  logic [index_width(DEPTH)-1:0]    rd_idx,
    output logic [DATA_WIDTH-1:0]            rd_q
);

    localparam int c_lanes = byte_lanes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_q;

    always_ff @(posedge clock) begin
        if (wr_en) begin
            for (int i = 0; i < c_lanes; i++) begin
                if (wr_byteena[i]) begin
                    r_mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Read register holds its value between loads so the response stays stable.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_q <= '0;
        end else if (rd_en) begin
            r_rd_q <= rd_zero ? '0 : r_mem[rd_idx];
        end
    end

    assign rd_q = r_rd_q;

endmodule
`default_nettype wire

// File: rtl/data_memory_hs.sv
`default_nettype none
// ============================================================================
// Module   : data_memory_hs
// Brief    : Data memory with valid/ready request/response handshake, byte
//            enables and LATENCY wait states. Define
//            DATA_MEMORY_HS_RANGE_CHECK_EN to report out-of-range accesses.
// Revision : 1.0 - initial release
// ============================================================================
module data_memory_hs
    import data_memory_hs_pkg::*;
#(
    parameter int ADDR_WIDTH = 15,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 2**ADDR_WIDTH,
    parameter int LATENCY    = 1
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_wren,
    input  logic [ADDR_WIDTH-1:0]   req_address,
    input  logic [DATA_WIDTH/8-1:0] req_byteena,
    input  logic [DATA_WIDTH-1:0]   req_data,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_q,
    output logic                    rsp_error
);

    localparam int c_idx_w = index_width(DEPTH);
    localparam logic [LATENCY_CNT_WIDTH-1:0] c_cnt_load =
        LATENCY_CNT_WIDTH'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic [LATENCY_CNT_WIDTH-1:0]   r_cnt;
    logic [LATENCY_CNT_WIDTH-1:0]   w_cnt_nxt;
    logic                           r_live;
    logic                           r_wren;
    logic [ADDR_WIDTH-1:0]          r_addr;
    logic                           w_accept;
    logic                           w_enter_resp;
    logic                           w_cur_wren;
    logic [ADDR_WIDTH-1:0]          w_cur_addr;
    logic                           w_in_range;
    logic                           w_wr_en;
    logic                           w_rd_zero;

    assign req_ready = r_live && (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);

    // In IDLE the live request is used so a zero-latency read can sample the
    // array at its own acceptance edge; otherwise the latched copy is used.
    assign w_cur_addr = (r_state == IDLE) ? req_address : r_addr;
    assign w_cur_wren = (r_state == IDLE) ? req_wren    : r_wren;

    generate
        if (DEPTH >= 2**ADDR_WIDTH) begin : g_full_map
            assign w_in_range = 1'b1;
        end else begin : g_range_cmp
            assign w_in_range = (w_cur_addr < ADDR_WIDTH'(DEPTH));
        end
    endgenerate

    assign w_wr_en   = w_accept && req_wren && w_in_range;
    assign w_rd_zero = w_cur_wren || !w_in_range;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_accept     = 1'b0;
        w_enter_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    w_accept = 1'b1;
                    if (LATENCY == 0) begin
                        w_state_nxt  = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = c_cnt_load;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt  = RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_live <= 1'b0;
            r_wren <= 1'b0;
            r_addr <= '0;
        end else begin
            r_live <= 1'b1;
            if (w_accept) begin
                r_wren <= req_wren;
                r_addr <= req_address;
            end
        end
    end

`ifdef DATA_MEMORY_HS_RANGE_CHECK_EN
    logic r_rsp_error;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rsp_error <= 1'b0;
        end else if (w_enter_resp) begin
            r_rsp_error <= !w_in_range;
        end
    end

    assign rsp_error = r_rsp_error;
`else
    assign rsp_error = 1'b0;
`endif

    data_memory_hs_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clock      (clock),
        .reset_n    (reset_n),
        .wr_en      (w_wr_en),
        .wr_idx     (req_address[c_idx_w-1:0]),
        .wr_byteena (req_byteena),
        .wr_data    (req_data),
        .rd_en      (w_enter_resp),
        .rd_zero    (w_rd_zero),
        .rd_idx     (w_cur_addr[c_idx_w-1:0]),
        .rd_q       (rsp_q)
    );

endmodule
`default_nettype wire

// File: tb/tb_data_memory_hs.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_memory_hs
// Brief    : Scoreboard bench for data_memory_hs; three instances with
//            LATENCY 1, 0 and 3 (index 0, 1, 2), DEPTH 16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_memory_hs;

    typedef struct packed {
        logic [31:0] q;
        logic        err;
    } exp_t;

`ifdef DATA_MEMORY_HS_RANGE_CHECK_EN
    localparam bit c_rc = 1'b1;
`else
    localparam bit c_rc = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic [2:0]  req_valid;
    logic [2:0]  req_wren;
    logic [2:0]  rsp_ready;
    logic [7:0]  req_address [3];
    logic [3:0]  req_byteena [3];
    logic [31:0] req_data    [3];
    wire  [2:0]  req_ready;
    wire  [2:0]  rsp_valid;
    wire  [2:0]  rsp_error;
    wire  [31:0] rsp_q       [3];

    logic [31:0] mdl [3][16];
    exp_t        sbq [$];
    int          n_vec = 0;
    int          n_err = 0;

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            data_memory_hs #(
                .ADDR_WIDTH (8),
                .DATA_WIDTH (32),
                .DEPTH      (16),
                .LATENCY    ((g == 0) ? 1 : (g == 1) ? 0 : 3)
            ) u_dut (
                .clock       (clock),
                .reset_n     (reset_n),
                .req_valid   (req_valid[g]),
                .req_ready   (req_ready[g]),
                .req_wren    (req_wren[g]),
                .req_address (req_address[g]),
                .req_byteena (req_byteena[g]),
                .req_data    (req_data[g]),
                .rsp_valid   (rsp_valid[g]),
                .rsp_ready   (rsp_ready[g]),
                .rsp_q       (rsp_q[g]),
                .rsp_error   (rsp_error[g])
            );
        end
    endgenerate

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 0 : 3;
    endfunction

    // Reference model: applies a transaction and returns the expected response.
    function automatic exp_t model_txn(input int d, input bit wr, input logic [7:0] addr,
                                       input logic [3:0] be, input logic [31:0] data);
        exp_t e;
        bit   inr;
        inr   = (addr < 8'd16);
        e.q   = 32'h0;
        e.err = c_rc && !inr;
        if (wr) begin
            if (inr) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) mdl[d][addr[3:0]][8*i +: 8] = data[8*i +: 8];
                end
            end
        end else if (inr) begin
            e.q = mdl[d][addr[3:0]];
        end
        return e;
    endfunction

    // Single transaction, entered and left on a falling edge.
    task automatic txn(input int d, input bit wr, input logic [7:0] addr,
                       input logic [3:0] be, input logic [31:0] data);
        int   guard;
        int   lat;
        exp_t e;
        guard = 0;
        while (req_ready[d] !== 1'b1 && guard < 50) begin
            @(negedge clock);
            guard++;
        end
        if (req_ready[d] !== 1'b1) begin
            n_vec++; n_err++;
            $display("FAIL ready_timeout dut%0d: req_ready=%b, want 1", d, req_ready[d]);
            return;
        end
        req_wren[d] = wr; req_address[d] = addr; req_byteena[d] = be; req_data[d] = data;
        req_valid[d] = 1'b1;
        @(posedge clock);
        sbq.push_back(model_txn(d, wr, addr, be, data));
        #1 req_valid[d] = 1'b0;
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (rsp_valid[d] !== 1'b1 && lat < 40);
        n_vec++;
        if (lat != lat_of(d) + 1) begin
            n_err++;
            $display("FAIL latency dut%0d addr=%0d: got %0d cycles, want %0d", d, addr, lat, lat_of(d) + 1);
        end
        e = sbq.pop_front();
        n_vec++;
        if (rsp_q[d] !== e.q || rsp_error[d] !== e.err) begin
            n_err++;
            $display("FAIL response dut%0d wr=%0d addr=%0d: got q=%h err=%b, want q=%h err=%b",
                     d, wr, addr, rsp_q[d], rsp_error[d], e.q, e.err);
        end
        rsp_ready[d] = 1'b1;
        @(posedge clock);
        #1 rsp_ready[d] = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if ({req_ready[d], rsp_valid[d], rsp_error[d]} !== 3'b000 || rsp_q[d] !== 32'h0) begin
                n_err++;
                $display("FAIL reset_values dut%0d: ready/valid/err=%b%b%b q=%h, want 000 q=0",
                         d, req_ready[d], rsp_valid[d], rsp_error[d], rsp_q[d]);
            end
        end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (req_ready[d] !== 1'b0) begin
                n_err++;
                $display("FAIL ready_before_edge dut%0d: got %b, want 0", d, req_ready[d]);
            end
        end
        @(negedge clock);
        for (int d = 0; d < 3; d++) begin
            n_vec++;
            if (req_ready[d] !== 1'b1) begin
                n_err++;
                $display("FAIL ready_after_edge dut%0d: got %b, want 1", d, req_ready[d]);
            end
        end
    endtask

    task automatic test_write_read();
        txn(0, 1'b1, 8'd5, 4'hF, 32'hDEAD_BEEF);
        txn(0, 1'b0, 8'd5, 4'h0, 32'h0);
    endtask

    task automatic test_byte_merge();
        txn(0, 1'b1, 8'd5, 4'b0010, 32'h0000_1200);
        txn(0, 1'b0, 8'd5, 4'h0, 32'h0);
        txn(0, 1'b1, 8'd5, 4'b0000, 32'hFFFF_FFFF);
        txn(0, 1'b0, 8'd5, 4'h0, 32'h0);
        txn(0, 1'b1, 8'd9, 4'b1001, 32'h1234_5678);
        txn(0, 1'b1, 8'd9, 4'b0110, 32'hAABB_CCDD);
        txn(0, 1'b0, 8'd9, 4'h0, 32'h0);
    endtask

    task automatic test_latency();
        for (int d = 1; d < 3; d++) begin
            txn(d, 1'b1, 8'd5, 4'hF, 32'hA5A5_0000 + d);
            txn(d, 1'b0, 8'd5, 4'h0, 32'h0);
        end
    endtask

    task automatic test_back_to_back(input int d);
        int   acc_cyc [$];
        int   cyc;
        int   guard;
        exp_t e;
        cyc = 0;
        req_wren[d] = 1'b0; req_address[d] = 8'd5; req_byteena[d] = 4'h0;
        req_valid[d] = 1'b1; rsp_ready[d] = 1'b1;
        while (acc_cyc.size() < 4 && cyc < 100) begin
            if (req_valid[d] && req_ready[d] === 1'b1) begin
                sbq.push_back(model_txn(d, 1'b0, 8'd5, 4'h0, 32'h0));
                acc_cyc.push_back(cyc);
            end
            if (rsp_valid[d] === 1'b1 && sbq.size() > 0) begin
                e = sbq.pop_front();
                n_vec++;
                if (rsp_q[d] !== e.q || rsp_error[d] !== e.err) begin
                    n_err++;
                    $display("FAIL b2b_response dut%0d: got q=%h err=%b, want q=%h err=%b",
                             d, rsp_q[d], rsp_error[d], e.q, e.err);
                end
            end
            @(negedge clock);
            cyc++;
        end
        req_valid[d] = 1'b0;
        guard = 0;
        while (sbq.size() > 0 && guard < 50) begin
            if (rsp_valid[d] === 1'b1) begin
                e = sbq.pop_front();
                n_vec++;
                if (rsp_q[d] !== e.q || rsp_error[d] !== e.err) begin
                    n_err++;
                    $display("FAIL b2b_drain dut%0d: got q=%h err=%b, want q=%h err=%b",
                             d, rsp_q[d], rsp_error[d], e.q, e.err);
                end
            end
            @(negedge clock);
            guard++;
        end
        n_vec++;
        if (acc_cyc.size() != 4 || sbq.size() != 0) begin
            n_err++;
            $display("FAIL b2b_count dut%0d: got %0d accepts %0d pending, want 4 and 0",
                     d, acc_cyc.size(), sbq.size());
            sbq.delete();
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            n_vec++;
            if (acc_cyc[i] - acc_cyc[i-1] != lat_of(d) + 2) begin
                n_err++;
                $display("FAIL issue_interval dut%0d: got %0d, want %0d",
                         d, acc_cyc[i] - acc_cyc[i-1], lat_of(d) + 2);
            end
        end
        rsp_ready[d] = 1'b0;
    endtask

    task automatic test_backpressure();
        int   guard;
        exp_t e;
        req_wren[0] = 1'b0; req_address[0] = 8'd5; req_byteena[0] = 4'h0;
        req_valid[0] = 1'b1;
        @(posedge clock);
        sbq.push_back(model_txn(0, 1'b0, 8'd5, 4'h0, 32'h0));
        #1 req_valid[0] = 1'b0;
        guard = 0;
        do begin
            @(negedge clock);
            guard++;
        end while (rsp_valid[0] !== 1'b1 && guard < 40);
        e = sbq.pop_front();
        for (int i = 0; i < 10; i++) begin
            n_vec++;
            if (rsp_valid[0] !== 1'b1 || req_ready[0] !== 1'b0 ||
                rsp_q[0] !== e.q || rsp_error[0] !== e.err) begin
                n_err++;
                $display("FAIL backpressure cycle %0d: valid=%b ready=%b q=%h err=%b, want 1 0 %h %b",
                         i, rsp_valid[0], req_ready[0], rsp_q[0], rsp_error[0], e.q, e.err);
            end
            @(negedge clock);
        end
        rsp_ready[0] = 1'b1;
        @(posedge clock);
        #1 rsp_ready[0] = 1'b0;
        @(negedge clock);
        n_vec++;
        if (req_ready[0] !== 1'b1 || rsp_valid[0] !== 1'b0) begin
            n_err++;
            $display("FAIL turnaround: req_ready=%b rsp_valid=%b, want 1 0", req_ready[0], rsp_valid[0]);
        end
    endtask

    task automatic test_reset_mid_wait();
        bool_check: begin
            bit seen;
            req_wren[2] = 1'b1; req_address[2] = 8'd7; req_byteena[2] = 4'hF;
            req_data[2] = 32'h0000_0011; req_valid[2] = 1'b1;
            @(posedge clock);
            void'(model_txn(2, 1'b1, 8'd7, 4'hF, 32'h0000_0011));
            #1 req_valid[2] = 1'b0;
            @(negedge clock);
            reset_n = 1'b0;
            #1;
            n_vec++;
            if (rsp_valid[2] !== 1'b0 || req_ready[2] !== 1'b0 || rsp_q[2] !== 32'h0) begin
                n_err++;
                $display("FAIL mid_reset_outputs: valid=%b ready=%b q=%h, want 0 0 0",
                         rsp_valid[2], req_ready[2], rsp_q[2]);
            end
            @(negedge clock);
            reset_n = 1'b1;
            seen = 1'b0;
            for (int i = 0; i < 8; i++) begin
                @(negedge clock);
                if (rsp_valid[2] !== 1'b0) seen = 1'b1;
            end
            n_vec++;
            if (seen) begin
                n_err++;
                $display("FAIL dropped_response: rsp_valid seen=%b, want 0", seen);
            end
        end
        txn(2, 1'b0, 8'd7, 4'h0, 32'h0);
    endtask

    task automatic test_range();
        txn(0, 1'b1, 8'd4,  4'hF, 32'h4444_4444);
        txn(0, 1'b1, 8'd20, 4'hF, 32'hCAFE_BABE);
        txn(0, 1'b0, 8'd4,  4'h0, 32'h0);
        txn(0, 1'b0, 8'd20, 4'h0, 32'h0);
        txn(0, 1'b0, 8'd15, 4'h0, 32'h0);
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = '0; req_wren = '0; rsp_ready = '0;
        for (int d = 0; d < 3; d++) begin
            req_address[d] = '0; req_byteena[d] = '0; req_data[d] = '0;
            mdl[d][15] = 32'h0;
        end
        test_reset();
        txn(0, 1'b1, 8'd15, 4'hF, 32'h0F0F_0F0F);
        test_write_read();
        test_byte_merge();
        test_latency();
        test_back_to_back(1);
        test_back_to_back(2);
        test_back_to_back(0);
        test_backpressure();
        test_reset_mid_wait();
        test_range();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
